// File: rtl/vv_alu_config_sequencer.sv
// vv_alu_config_sequencer
// Buffers host firmware bytes in a small FIFO, pauses lane tracing so the ALU
// pipeline can drain, streams one uninterrupted block on configId/configData
// to the selected target, parks configId at the idle ID, then restores tracing.
// Optional feature macro: CFG_TIMEOUT_EN (bounded wait for FIFO fill in DRAIN).
module vv_alu_config_sequencer #(
    parameter int         FIFO_DEPTH     = 32,
    parameter int         DRAIN_CYCLES   = 4,
    parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trace_enable,
    input  logic       cfg_byte_valid,
    input  logic [7:0] cfg_byte,
    output logic       cfg_byte_ready,
    input  logic       cfg_start,
    input  logic [7:0] cfg_target_id,
    input  logic [7:0] cfg_len,
    output logic       tracing,
    output logic [7:0] configId,
    output logic [7:0] configData,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    // Parameter sanity: a bad configuration stops elaboration instead of misbehaving
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (DRAIN_CYCLES < 1) begin : gBadDrain
        $error("DRAIN_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DRAIN, STREAM, GAP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     fifoMem [FIFO_DEPTH];
    logic [AW-1:0]  wrPtr_q, rdPtr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [DW-1:0]  drainCnt_q, drainCnt_d;
    logic [7:0]     target_q, target_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     streamCnt_q, streamCnt_d;
    logic           error_q, error_d;
    logic           tracing_q, done_q, busy_q;
    logic [7:0]     configId_q, configData_q;
    logic           full, push, pop;

`ifdef CFG_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]  waitCnt_q, waitCnt_d;
`endif

    assign full           = (count_q == CW'(FIFO_DEPTH));
    assign cfg_byte_ready = !full;
    assign push           = cfg_byte_valid && !full;
    assign pop            = (state_d == STREAM);
    assign count_d        = count_q + CW'(push) - CW'(pop);

    assign tracing    = tracing_q;
    assign configId   = configId_q;
    assign configData = configData_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

    // Next-state logic: block acceptance, drain timing, stream length and the one-cycle gap
    always_comb begin
        state_d     = state_q;
        drainCnt_d  = drainCnt_q;
        target_d    = target_q;
        len_d       = len_q;
        streamCnt_d = streamCnt_q;
        error_d     = error_q;
`ifdef CFG_TIMEOUT_EN
        waitCnt_d   = waitCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (32'(cfg_len) > FIFO_DEPTH) begin
                        error_d = 1'b1;
                    end else begin
                        target_d   = cfg_target_id;
                        len_d      = cfg_len;
                        error_d    = 1'b0;
                        drainCnt_d = '0;
                        state_d    = DRAIN;
`ifdef CFG_TIMEOUT_EN
                        waitCnt_d  = '0;
`endif
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q != DW'(DRAIN_CYCLES)) begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
                if (drainCnt_d == DW'(DRAIN_CYCLES)) begin
                    if (len_q == 8'd0) begin
                        state_d = GAP;
                    end else if (32'(count_q) >= 32'(len_q)) begin
                        state_d     = STREAM;
                        streamCnt_d = 8'd1;
                    end
`ifdef CFG_TIMEOUT_EN
                    else if (drainCnt_q == DW'(DRAIN_CYCLES)) begin
                        waitCnt_d = waitCnt_q + 1'b1;
                        if (waitCnt_d == WW'(TIMEOUT_CYCLES)) begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
`endif
                end
            end
            STREAM: begin
                if (streamCnt_q == len_q) begin
                    state_d = GAP;
                end else begin
                    streamCnt_d = streamCnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, FIFO pointers and registered bus outputs; reset flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            drainCnt_q   <= '0;
            target_q     <= '0;
            len_q        <= '0;
            streamCnt_q  <= '0;
            error_q      <= 1'b0;
            tracing_q    <= 1'b0;
            configId_q   <= IDLE_CONFIG_ID;
            configData_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            drainCnt_q   <= drainCnt_d;
            target_q     <= target_d;
            len_q        <= len_d;
            streamCnt_q  <= streamCnt_d;
            error_q      <= error_d;
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            tracing_q    <= (state_q == IDLE && state_d == IDLE) ? trace_enable : 1'b0;
            configId_q   <= pop ? target_q : IDLE_CONFIG_ID;
            configData_q <= pop ? fifoMem[rdPtr_q] : 8'd0;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == GAP);
        end
    end

    // FIFO storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr_q] <= cfg_byte;
    end

`ifdef CFG_TIMEOUT_EN
    // Counts DRAIN cycles spent waiting for bytes once the drain period is over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) waitCnt_q <= '0;
        else     waitCnt_q <= waitCnt_d;
    end
`endif

endmodule
